// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous level, plus a history flop
// that turns the synchronized level into a single-cycle rising-edge pulse.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    // Shift the raw input through the synchronizer chain; remember the previous synchronized level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/serial_frame_capture.sv
// Oversampling capture of a serial clk/latch/data display interface.
// Rebuilds each latched frame into parallel words (one per data channel),
// checks the bit count per frame and flags length errors.
module serial_frame_capture #(
    parameter int SHIFT_WIDTH = 48,
    parameter int CHANNELS    = 1,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_en,
    input  logic                         i_clear_err,
    input  logic                         i_serial_clk,
    input  logic                         i_serial_latch,
    input  logic [CHANNELS-1:0]          i_serial_data,
    output logic [CHANNELS*SHIFT_WIDTH-1:0] o_parallel_data,
    output logic                         o_frame_valid,
    output logic                         o_frame_error,
    output logic [15:0]                  o_frame_count
);

    localparam int COUNT_W = $clog2(SHIFT_WIDTH + 2);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(SHIFT_WIDTH);
    localparam logic [COUNT_W-1:0] SAT_COUNT  = COUNT_W'(SHIFT_WIDTH + 1);

    logic                           sclk_level;
    logic                           sclk_rise;
    logic                           latch_level;
    logic                           latch_rise;
    logic [CHANNELS-1:0]            data_sync_reg [SYNC_STAGES];
    logic [CHANNELS-1:0]            data_level;
    logic [CHANNELS*SHIFT_WIDTH-1:0] shift_reg;
    logic [CHANNELS*SHIFT_WIDTH-1:0] shift_next;
    logic [CHANNELS*SHIFT_WIDTH-1:0] frame_next;
    logic [COUNT_W-1:0]             count_reg;
    logic [COUNT_W-1:0]             count_next;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (i_clk),
        .rst   (i_reset),
        .din   (i_serial_clk),
        .level (sclk_level),
        .rise  (sclk_rise)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk   (i_clk),
        .rst   (i_reset),
        .din   (i_serial_latch),
        .level (latch_level),
        .rise  (latch_rise)
    );

    // Data synchronizer of the same depth keeps each data bit aligned with the synchronized sclk
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                data_sync_reg[s] <= '0;
            end
        end else begin
            data_sync_reg[0] <= i_serial_data;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                data_sync_reg[s] <= data_sync_reg[s-1];
            end
        end
    end

    assign data_level = data_sync_reg[SYNC_STAGES-1];

    // Per-channel next shift value; frame_next includes a same-cycle shift so a frame can complete as it latches
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            if (MSB_FIRST != 0) begin : g_msb
                assign shift_next[gi*SHIFT_WIDTH +: SHIFT_WIDTH] =
                    {shift_reg[gi*SHIFT_WIDTH +: SHIFT_WIDTH-1], data_level[gi]};
            end else begin : g_lsb
                assign shift_next[gi*SHIFT_WIDTH +: SHIFT_WIDTH] =
                    {data_level[gi], shift_reg[gi*SHIFT_WIDTH+1 +: SHIFT_WIDTH-1]};
            end
        end
    endgenerate

    assign frame_next = sclk_rise ? shift_next : shift_reg;
    assign count_next = !sclk_rise ? count_reg :
                        (count_reg == SAT_COUNT) ? SAT_COUNT : count_reg + 1'b1;

    // Shift registers advance on each enabled sclk rise and are never cleared by a latch
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_reg <= '0;
        end else if (i_en && sclk_rise) begin
            shift_reg <= shift_next;
        end
    end

    // Bit counting, frame judgement on latch rise, sticky error with set priority over clear
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_reg       <= '0;
            o_parallel_data <= '0;
            o_frame_valid   <= 1'b0;
            o_frame_error   <= 1'b0;
            o_frame_count   <= '0;
        end else begin
            o_frame_valid <= 1'b0;
            if (i_clear_err) begin
                o_frame_error <= 1'b0;
            end
            if (i_en) begin
                if (latch_rise) begin
                    count_reg <= '0;
                    if (count_next == FULL_COUNT) begin
                        o_parallel_data <= frame_next;
                        o_frame_valid   <= 1'b1;
                        o_frame_count   <= o_frame_count + 16'd1;
                    end else begin
                        o_frame_error <= 1'b1;
                    end
                end else begin
                    count_reg <= count_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_capture.sv
// Scoreboard bench: stimulus pushes expected frames, a monitor pops and
// compares on every o_frame_valid pulse; direct checks cover flags/holds.
module tb_serial_frame_capture;

    typedef struct packed {
        logic [47:0] data;
        logic [15:0] count;
    } exp_a_t;

    typedef struct packed {
        logic [23:0] data;
        logic [15:0] count;
    } exp_b_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        clear_err = 1'b0;
    logic        a_sclk = 1'b0;
    logic        a_latch = 1'b0;
    logic [0:0]  a_data = 1'b0;
    logic [47:0] a_par;
    logic        a_valid;
    logic        a_err;
    logic [15:0] a_cnt;
    logic        b_sclk = 1'b0;
    logic        b_latch = 1'b0;
    logic [2:0]  b_data = 3'b0;
    logic [23:0] b_par;
    logic        b_valid;
    logic        b_err;
    logic [15:0] b_cnt;

    exp_a_t a_q[$];
    exp_b_t b_q[$];
    int compared = 0;
    int mismatched = 0;

    localparam logic [47:0] F1 = 48'hA5A5_0F0F_1234;
    localparam logic [47:0] F2 = 48'h1234_5678_9ABC;
    localparam logic [47:0] F3 = 48'hFEDC_BA98_7654;
    localparam logic [47:0] F4 = 48'h0F1E_2D3C_4B5A;
    localparam logic [47:0] F5 = 48'h8001_7FFE_C3C3;

    always #5 clk = ~clk;

    serial_frame_capture u_dut_a (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_en            (en),
        .i_clear_err     (clear_err),
        .i_serial_clk    (a_sclk),
        .i_serial_latch  (a_latch),
        .i_serial_data   (a_data),
        .o_parallel_data (a_par),
        .o_frame_valid   (a_valid),
        .o_frame_error   (a_err),
        .o_frame_count   (a_cnt)
    );

    serial_frame_capture #(
        .SHIFT_WIDTH (8),
        .CHANNELS    (3),
        .MSB_FIRST   (0),
        .SYNC_STAGES (2)
    ) u_dut_b (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_en            (1'b1),
        .i_clear_err     (1'b0),
        .i_serial_clk    (b_sclk),
        .i_serial_latch  (b_latch),
        .i_serial_data   (b_data),
        .o_parallel_data (b_par),
        .o_frame_valid   (b_valid),
        .o_frame_error   (b_err),
        .o_frame_count   (b_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic a_bit(input logic b);
        a_data = b;
        cyc(2);
        a_sclk = 1'b1;
        cyc(4);
        a_sclk = 1'b0;
        cyc(2);
    endtask

    // Sends the n low bits of v, highest-numbered bit first
    task automatic a_frame(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) a_bit(v[i]);
    endtask

    task automatic a_pulse_latch();
        a_latch = 1'b1;
        cyc(4);
        a_latch = 1'b0;
        cyc(8);
    endtask

    task automatic a_good_frame(input logic [47:0] v, input logic [15:0] cnt);
        exp_a_t e;
        e.data  = v;
        e.count = cnt;
        a_frame(64'(v), 48);
        a_q.push_back(e);
        a_pulse_latch();
        check("a_frame_seen", 64'(a_q.size()), 64'd0);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        cyc(1);
        clear_err = 1'b0;
        cyc(1);
    endtask

    // Monitor: every valid pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (!rst) begin
            if (a_valid) begin
                compared++;
                if (a_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL a_unexpected_valid: got data 0x%0h count %0d expected no frame", a_par, a_cnt);
                end else begin
                    exp_a_t e;
                    e = a_q.pop_front();
                    if (a_par !== e.data || a_cnt !== e.count) begin
                        mismatched++;
                        $display("FAIL a_frame: got data 0x%0h count %0d expected data 0x%0h count %0d",
                                 a_par, a_cnt, e.data, e.count);
                    end else begin
                        $display("ok   a_frame: data 0x%0h count %0d", a_par, a_cnt);
                    end
                end
            end
            if (b_valid) begin
                compared++;
                if (b_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL b_unexpected_valid: got data 0x%0h expected no frame", b_par);
                end else begin
                    exp_b_t e;
                    e = b_q.pop_front();
                    if (b_par !== e.data || b_cnt !== e.count) begin
                        mismatched++;
                        $display("FAIL b_frame: got data 0x%0h count %0d expected data 0x%0h count %0d",
                                 b_par, b_cnt, e.data, e.count);
                    end else begin
                        $display("ok   b_frame: data 0x%0h count %0d", b_par, b_cnt);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_b_t eb;
        logic [7:0] c0, c1, c2;

        cyc(3);
        check("reset_par", 64'(a_par), 64'd0);
        check("reset_valid", 64'(a_valid), 64'd0);
        check("reset_err", 64'(a_err), 64'd0);
        check("reset_count", 64'(a_cnt), 64'd0);
        rst = 1'b0;
        cyc(3);

        // Basic 48-bit MSB-first frame
        a_good_frame(F1, 16'd1);
        check("f1_err", 64'(a_err), 64'd0);

        // Short frame: error, data held
        a_frame(64'(F2), 47);
        a_pulse_latch();
        check("short_err", 64'(a_err), 64'd1);
        check("short_hold", 64'(a_par), 64'(F1));
        pulse_clear();
        check("short_clear", 64'(a_err), 64'd0);
        a_good_frame(F2, 16'd2);

        // Long frame: error, data held, then recovery
        a_frame(64'h0003_FFFF_0000_FFFF, 50);
        a_pulse_latch();
        check("long_err", 64'(a_err), 64'd1);
        check("long_hold", 64'(a_par), 64'(F2));
        pulse_clear();
        a_good_frame(F3, 16'd3);
        check("f3_err", 64'(a_err), 64'd0);

        // Disabled: pulses and latch ignored
        en = 1'b0;
        a_frame(64'(F4), 48);
        a_pulse_latch();
        check("dis_count", 64'(a_cnt), 64'd3);
        check("dis_par", 64'(a_par), 64'(F3));
        check("dis_err", 64'(a_err), 64'd0);
        // Enable while sclk is high: must not register a shift
        a_sclk = 1'b1;
        cyc(4);
        en = 1'b1;
        cyc(4);
        a_sclk = 1'b0;
        cyc(4);
        a_good_frame(F4, 16'd4);
        check("en_err", 64'(a_err), 64'd0);

        // Reset mid-frame
        a_frame(64'(F1), 20);
        rst = 1'b1;
        #2;
        check("midrst_par", 64'(a_par), 64'd0);
        check("midrst_count", 64'(a_cnt), 64'd0);
        check("midrst_err", 64'(a_err), 64'd0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        a_good_frame(F5, 16'd1);
        check("postrst_err", 64'(a_err), 64'd0);

        // Three-channel LSB-first instance
        c0 = 8'h01;
        c1 = 8'h80;
        c2 = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            b_data = {c2[i], c1[i], c0[i]};
            cyc(2);
            b_sclk = 1'b1;
            cyc(4);
            b_sclk = 1'b0;
            cyc(2);
        end
        eb.data  = 24'h3C_80_01;
        eb.count = 16'd1;
        b_q.push_back(eb);
        b_latch = 1'b1;
        cyc(4);
        b_latch = 1'b0;
        cyc(8);
        check("b_frame_seen", 64'(b_q.size()), 64'd0);
        check("b_err", 64'(b_err), 64'd0);

        cyc(4);
        check("a_queue_empty", 64'(a_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
